// File: rtl/packet_rx_if.sv
// Decoded-packet bus of the UART packet receiver, plus its serial input line.
// The packet_rx master samples rx and drives the decoded fields; the decoder side is the slave.
interface packet_rx_if;
    logic         rx;
    logic [7:0]   cmd;
    logic [15:0]  len;
    logic [255:0] payload;
    logic         valid;
    logic         busy;
    logic         err;
    logic [1:0]   err_code;

    modport master (
        input  rx,
        output cmd, len, payload, valid, busy, err, err_code
    );

    modport slave (
        output rx,
        input  cmd, len, payload, valid, busy, err, err_code
    );
endinterface

// File: rtl/packet_rx.sv
// UART 8N1 receiver plus packet framer/validator: 55 AA cmd lenA lenB payload[32].
// Define PACKET_RX_TIMEOUT_EN to abort stalled packets after TIMEOUT_CLKS idle clocks.
module packet_rx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned MAX_LEN      = 32,
    parameter int unsigned TIMEOUT_CLKS = 20000
) (
    input  logic        clock,
    input  logic        reset,
    packet_rx_if.master pr
);
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF = CLKS_PER_BIT / 2;

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
    typedef enum logic [3:0] {
        P_HUNT0, P_HUNT1, P_CMD, P_LA_H, P_LA_L, P_LB_H, P_LB_L, P_PAY, P_CHECK
    } pstate_t;

    logic          rx_meta, rx_s;
    bstate_t       bstate;
    logic [CW-1:0] bcnt;
    logic [2:0]    bidx;
    logic [7:0]    shreg;
    logic          brk;
    logic          byte_stb, frame_err;
    logic          timeout_hit;

    pstate_t       pstate;
    logic [4:0]    pcnt;
    logic [7:0]    cmd_sh;
    logic [15:0]   len_a, len_b;
    logic [255:0]  pay_sh;
    logic [7:0]    cmd_q;
    logic [15:0]   len_q;
    logic [255:0]  pay_q;
    logic          valid_q, err_q;
    logic [1:0]    code_q;

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= pr.rx;
            rx_s    <= rx_meta;
        end
    end

    // Bit receiver; brk marks a failed stop bit still waiting for the line to return high.
    always_ff @(posedge clock) begin
        if (reset || timeout_hit) begin
            bstate    <= B_IDLE;
            bcnt      <= '0;
            bidx      <= '0;
            shreg     <= '0;
            brk       <= 1'b0;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
            case (bstate)
                B_IDLE: begin
                    bcnt <= '0;
                    if (!rx_s) bstate <= B_START;
                end
                B_START: begin
                    if (bcnt == CW'(HALF)) begin
                        bcnt   <= '0;
                        bidx   <= '0;
                        bstate <= rx_s ? B_IDLE : B_DATA;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                B_DATA: begin
                    if (bcnt == CW'(CLKS_PER_BIT - 1)) begin
                        bcnt  <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bidx == 3'd7) bstate <= B_STOP;
                        else              bidx   <= bidx + 1'b1;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                B_STOP: begin
                    if (brk) begin
                        if (rx_s) begin
                            brk    <= 1'b0;
                            bstate <= B_IDLE;
                        end
                    end else if (bcnt == CW'(CLKS_PER_BIT - 1)) begin
                        bcnt <= '0;
                        if (rx_s) begin
                            byte_stb <= 1'b1;
                            bstate   <= B_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            brk       <= 1'b1;
                        end
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                default: bstate <= B_IDLE;
            endcase
        end
    end

`ifdef PACKET_RX_TIMEOUT_EN
    localparam int unsigned GW = $clog2(TIMEOUT_CLKS + 1);
    logic [GW-1:0] gap;
    logic          in_window;

    assign in_window   = (pstate >= P_CMD) && (pstate <= P_PAY);
    assign timeout_hit = in_window && !byte_stb && (gap == GW'(TIMEOUT_CLKS - 1));

    // Inter-byte gap counter, live only while a packet body is in flight.
    always_ff @(posedge clock) begin
        if (reset || byte_stb || !in_window || timeout_hit) gap <= '0;
        else                                              gap <= gap + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
    wire unused_timeout = ^32'(TIMEOUT_CLKS);
`endif

    // Packet framer; shadows are only copied to the outputs after a clean CHECK.
    always_ff @(posedge clock) begin
        if (reset) begin
            pstate  <= P_HUNT0;
            pcnt    <= '0;
            cmd_sh  <= '0;
            len_a   <= '0;
            len_b   <= '0;
            pay_sh  <= '0;
            cmd_q   <= '0;
            len_q   <= '0;
            pay_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (frame_err) begin
                if (pstate != P_HUNT0 && pstate != P_HUNT1) begin
                    err_q  <= 1'b1;
                    code_q <= 2'd0;
                end
                pstate <= P_HUNT0;
            end else if (timeout_hit) begin
                err_q  <= 1'b1;
                code_q <= 2'd3;
                pstate <= P_HUNT0;
            end else begin
                case (pstate)
                    P_HUNT0: if (byte_stb && shreg == 8'h55) pstate <= P_HUNT1;
                    P_HUNT1: if (byte_stb) begin
                        if (shreg == 8'hAA)      pstate <= P_CMD;
                        else if (shreg == 8'h55) pstate <= P_HUNT1;
                        else                     pstate <= P_HUNT0;
                    end
                    P_CMD:  if (byte_stb) begin cmd_sh       <= shreg; pstate <= P_LA_H; end
                    P_LA_H: if (byte_stb) begin len_a[15:8]  <= shreg; pstate <= P_LA_L; end
                    P_LA_L: if (byte_stb) begin len_a[7:0]   <= shreg; pstate <= P_LB_H; end
                    P_LB_H: if (byte_stb) begin len_b[15:8]  <= shreg; pstate <= P_LB_L; end
                    P_LB_L: if (byte_stb) begin
                        len_b[7:0] <= shreg;
                        pcnt       <= '0;
                        pstate     <= P_PAY;
                    end
                    P_PAY: if (byte_stb) begin
                        pay_sh <= {pay_sh[247:0], shreg};
                        pcnt   <= pcnt + 1'b1;
                        if (pcnt == 5'd31) pstate <= P_CHECK;
                    end
                    P_CHECK: begin
                        if (len_a != len_b) begin
                            err_q  <= 1'b1;
                            code_q <= 2'd1;
                        end else if (len_a > 16'(MAX_LEN)) begin
                            err_q  <= 1'b1;
                            code_q <= 2'd2;
                        end else begin
                            cmd_q   <= cmd_sh;
                            len_q   <= len_a;
                            pay_q   <= pay_sh;
                            valid_q <= 1'b1;
                        end
                        pstate <= P_HUNT0;
                    end
                    default: pstate <= P_HUNT0;
                endcase
            end
        end
    end

    assign pr.cmd      = cmd_q;
    assign pr.len      = len_q;
    assign pr.payload  = pay_q;
    assign pr.valid    = valid_q;
    assign pr.err      = err_q;
    assign pr.err_code = code_q;
    assign pr.busy     = (pstate != P_HUNT0);
endmodule

// File: tb/tb_packet_rx.sv
// Directed bench for packet_rx at CLKS_PER_BIT=4; the timeout case runs when PACKET_RX_TIMEOUT_EN is defined.
module tb_packet_rx;
    localparam int unsigned CPB = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   valid_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic busy_prev = 1'b0, busy_at_valid = 1'b0, busy_before_valid = 1'b0;
    logic [1:0] last_code = 2'd0;
    logic [7:0] frame [39];

    packet_rx_if pr_if ();

    packet_rx #(.CLKS_PER_BIT(CPB), .MAX_LEN(32), .TIMEOUT_CLKS(200)) dut (
        .clock (clock),
        .reset (reset),
        .pr    (pr_if.master)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (pr_if.valid) begin
            valid_cnt         <= valid_cnt + 1;
            busy_at_valid     <= pr_if.busy;
            busy_before_valid <= busy_prev;
        end
        if (pr_if.err) begin
            err_cnt   <= err_cnt + 1;
            last_code <= pr_if.err_code;
        end
        if (pr_if.valid && pr_if.err) both_cnt <= both_cnt + 1;
        busy_prev <= pr_if.busy;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        pr_if.rx = v;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    // mode 0: payload byte k = k; mode 1: all 0xA5
    task automatic build_frame(input logic [7:0] c, input logic [15:0] la, input logic [15:0] lb,
                               input int mode);
        frame[0] = 8'h55; frame[1] = 8'hAA; frame[2] = c;
        frame[3] = la[15:8]; frame[4] = la[7:0];
        frame[5] = lb[15:8]; frame[6] = lb[7:0];
        for (int k = 0; k < 32; k++) frame[7+k] = (mode == 0) ? 8'(k) : 8'hA5;
    endtask

    task automatic send_frame(input int nbytes);
        for (int i = 0; i < nbytes; i++) send_byte(frame[i], 1'b1);
        repeat (12) @(negedge clock);
    endtask

    logic [255:0] exp_ramp, exp_a5;
    int v0, e0, waited;

    initial begin
        pr_if.rx = 1'b1;
        for (int k = 0; k < 32; k++) begin
            exp_ramp[255-8*k -: 8] = 8'(k);
            exp_a5[255-8*k -: 8]   = 8'hA5;
        end
        repeat (5) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        check("rst_cmd", 256'(pr_if.cmd), 256'h0);
        check("rst_len", 256'(pr_if.len), 256'h0);
        check("rst_payload", pr_if.payload, 256'h0);
        check("rst_flags", 256'({pr_if.valid, pr_if.busy, pr_if.err, pr_if.err_code}), 256'h0);

        // Basic packet
        v0 = valid_cnt; e0 = err_cnt;
        build_frame(8'h12, 16'h0005, 16'h0005, 0);
        send_frame(39);
        check("p1_valid_cnt", 256'(valid_cnt - v0), 256'd1);
        check("p1_err_cnt", 256'(err_cnt - e0), 256'd0);
        check("p1_cmd", 256'(pr_if.cmd), 256'h12);
        check("p1_len", 256'(pr_if.len), 256'd5);
        check("p1_pay_first", 256'(pr_if.payload[255:248]), 256'h00);
        check("p1_pay_last", 256'(pr_if.payload[7:0]), 256'h1F);
        check("p1_payload", pr_if.payload, exp_ramp);
        check("p1_busy_at_valid", 256'(busy_at_valid), 256'd0);
        check("p1_busy_before_valid", 256'(busy_before_valid), 256'd1);

        // Hunt recovery through 00 55 55 AA
        v0 = valid_cnt; e0 = err_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'h55, 1'b1);
        build_frame(8'h34, 16'h0020, 16'h0020, 1);
        send_frame(39);
        check("p2_valid_cnt", 256'(valid_cnt - v0), 256'd1);
        check("p2_err_cnt", 256'(err_cnt - e0), 256'd0);
        check("p2_cmd", 256'(pr_if.cmd), 256'h34);
        check("p2_len", 256'(pr_if.len), 256'd32);
        check("p2_payload", pr_if.payload, exp_a5);

        // Length copies differ
        v0 = valid_cnt; e0 = err_cnt;
        build_frame(8'h56, 16'h0005, 16'h0006, 0);
        send_frame(39);
        check("mis_err_cnt", 256'(err_cnt - e0), 256'd1);
        check("mis_code", 256'(last_code), 256'd1);
        check("mis_valid_cnt", 256'(valid_cnt - v0), 256'd0);
        check("mis_cmd_held", 256'(pr_if.cmd), 256'h34);
        check("mis_len_held", 256'(pr_if.len), 256'd32);
        check("mis_pay_held", pr_if.payload, exp_a5);

        // Length above MAX_LEN, then a good packet
        v0 = valid_cnt; e0 = err_cnt;
        build_frame(8'h66, 16'h0021, 16'h0021, 0);
        send_frame(39);
        check("big_err_cnt", 256'(err_cnt - e0), 256'd1);
        check("big_code", 256'(last_code), 256'd2);
        check("big_valid_cnt", 256'(valid_cnt - v0), 256'd0);
        check("big_cmd_held", 256'(pr_if.cmd), 256'h34);
        v0 = valid_cnt;
        build_frame(8'h77, 16'h0003, 16'h0003, 0);
        send_frame(39);
        check("p3_valid_cnt", 256'(valid_cnt - v0), 256'd1);
        check("p3_cmd", 256'(pr_if.cmd), 256'h77);
        check("p3_len", 256'(pr_if.len), 256'd3);

        // Framing error on the cmd byte
        v0 = valid_cnt; e0 = err_cnt;
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h99, 1'b0);
        send_bit(1'b1);
        repeat (20) @(negedge clock);
        check("fr_err_cnt", 256'(err_cnt - e0), 256'd1);
        check("fr_code", 256'(last_code), 256'd0);
        check("fr_busy", 256'(pr_if.busy), 256'd0);

        // Short glitch must be ignored
        e0 = err_cnt;
        pr_if.rx = 1'b0;
        repeat (3) @(negedge clock);
        pr_if.rx = 1'b1;
        repeat (60) @(negedge clock);
        check("gl_err_cnt", 256'(err_cnt - e0), 256'd0);
        check("gl_valid_cnt", 256'(valid_cnt - v0), 256'd0);
        check("gl_busy", 256'(pr_if.busy), 256'd0);
        build_frame(8'h5A, 16'h0010, 16'h0010, 1);
        send_frame(39);
        check("p4_valid_cnt", 256'(valid_cnt - v0), 256'd1);
        check("p4_cmd", 256'(pr_if.cmd), 256'h5A);

        // Reset in the middle of the payload
        v0 = valid_cnt;
        build_frame(8'h21, 16'h0004, 16'h0004, 0);
        for (int i = 0; i < 27; i++) send_byte(frame[i], 1'b1);
        repeat (10) @(negedge clock);
        check("mid_busy_pre", 256'(pr_if.busy), 256'd1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_busy_post", 256'(pr_if.busy), 256'd0);
        reset = 1'b0;
        repeat (200) @(negedge clock);
        check("mid_valid_cnt", 256'(valid_cnt - v0), 256'd0);
        check("mid_cmd_cleared", 256'(pr_if.cmd), 256'h0);
        check("mid_busy_idle", 256'(pr_if.busy), 256'd0);

`ifdef PACKET_RX_TIMEOUT_EN
        // Stall after payload byte 10
        v0 = valid_cnt; e0 = err_cnt;
        build_frame(8'h44, 16'h0002, 16'h0002, 0);
        for (int i = 0; i < 17; i++) send_byte(frame[i], 1'b1);
        waited = 0;
        while (err_cnt == e0 && waited < 400) begin
            @(negedge clock);
            waited++;
        end
        check("to_err_seen", 256'(err_cnt - e0), 256'd1);
        check("to_code", 256'(last_code), 256'd3);
        check("to_gap_min", 256'(waited >= 195), 256'd1);
        check("to_gap_max", 256'(waited <= 215), 256'd1);
        check("to_valid_cnt", 256'(valid_cnt - v0), 256'd0);
        send_frame(39);
        check("to_recover_valid", 256'(valid_cnt - v0), 256'd1);
        check("to_recover_cmd", 256'(pr_if.cmd), 256'h44);
`endif

        check("valid_err_overlap", 256'(both_cnt), 256'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
